// File: rtl/reglk_arbiter.sv
// Two-requester round-robin arbiter with a sticky region-lock register in front of
// the shared data memory. Every access takes IDLE -> ACCESS -> RESP.
module reglk_arbiter #(
    parameter int          NUM_LOCKS    = 6,
    parameter logic [31:0] LOCK_ADDR    = 32'h0000_0060,
    parameter logic [31:0] LOCK_BASE    = 32'h0000_0080,
    parameter int          REGION_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           m_req,
    input  logic [1:0]           m_we,
    input  logic [5:0]           m_width,
    input  logic [63:0]          m_addr,
    input  logic [63:0]          m_wdata,
    output logic [1:0]           m_gnt,
    output logic [1:0]           m_rvalid,
    output logic [31:0]          m_rdata,
    output logic [1:0]           m_err,
    output logic                 mem_we,
    output logic [2:0]           mem_width,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    output logic [NUM_LOCKS-1:0] lock_bits,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [2:0]  W_SB = 3'b000, W_SH = 3'b001, W_W = 3'b010, W_UH = 3'b101;
    localparam logic [31:0] MEM_BYTES    = 32'd800;
    localparam logic [31:0] REGION_BYTES = 32'(REGION_WORDS * 4);

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  id_q, id_d;
    logic                  we_q, we_d;
    logic [2:0]            width_q, width_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [NUM_LOCKS-1:0]  lock_q, lock_d;
    logic [1:0]            rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            err_q, err_d;

    logic        win;
    logic        illegal, misaligned, is_lock, out_of_range, locked_hit;
    logic        cmd_err, lock_wr, mem_wr_ok;
    logic [31:0] resp_data;

    // On a tie the pointer decides; a lone requester always wins.
    assign win = (m_req == 2'b11) ? ptr_q : m_req[1];

    always_comb begin
        illegal      = (width_q == 3'b011) || (width_q == 3'b110) || (width_q == 3'b111);
        misaligned   = (((width_q == W_SH) || (width_q == W_UH)) && addr_q[0]) ||
                       ((width_q == W_W) && (addr_q[1:0] != 2'b00));
        is_lock      = (addr_q == LOCK_ADDR);
        out_of_range = (addr_q >= MEM_BYTES) && !is_lock;
        locked_hit   = 1'b0;
        for (int k = 0; k < NUM_LOCKS; k++) begin
            if (lock_q[k] && (addr_q >= LOCK_BASE + REGION_BYTES * 32'(k)) &&
                (addr_q < LOCK_BASE + REGION_BYTES * 32'(k + 1)))
                locked_hit = 1'b1;
        end
        cmd_err   = illegal || (is_lock ? (width_q != W_W)
                                        : (misaligned || out_of_range || (we_q && locked_hit)));
        lock_wr   = is_lock && we_q && !cmd_err;
        mem_wr_ok = we_q && !is_lock && !cmd_err;
        resp_data = 32'h0;
        if (!cmd_err && !we_q)
            resp_data = is_lock ? {{(32 - NUM_LOCKS){1'b0}}, lock_q} : mem_rdata;
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        we_d     = we_q;
        width_d  = width_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lock_d   = lock_q;
        rvalid_d = 2'b00;
        rdata_d  = 32'h0;
        err_d    = 2'b00;
        case (state_q)
            IDLE: begin
                if (|m_req) begin
                    id_d    = win;
                    we_d    = win ? m_we[1] : m_we[0];
                    width_d = win ? m_width[5:3] : m_width[2:0];
                    addr_d  = win ? m_addr[63:32] : m_addr[31:0];
                    wdata_d = win ? m_wdata[63:32] : m_wdata[31:0];
                    ptr_d   = ~win;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rvalid_d = id_q ? 2'b10 : 2'b01;
                err_d    = cmd_err ? rvalid_d : 2'b00;
                rdata_d  = resp_data;
                if (lock_wr)
                    lock_d = lock_q | wdata_q[NUM_LOCKS-1:0];
                state_d  = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            width_q  <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            lock_q   <= '0;
            rvalid_q <= 2'b00;
            rdata_q  <= 32'h0;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            we_q     <= we_d;
            width_q  <= width_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lock_q   <= lock_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Memory strobes come straight off the state register so an async reset kills
    // mem_we before the memory's negedge write can happen.
    assign m_gnt     = (state_q == IDLE && |m_req && !rst) ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign mem_we    = (state_q == ACCESS) && mem_wr_ok;
    assign mem_width = (state_q == ACCESS) ? width_q : W_SB;
    assign mem_addr  = (state_q == ACCESS) ? addr_q : 32'h0;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : 32'h0;
    assign m_rvalid  = rvalid_q;
    assign m_rdata   = rdata_q;
    assign m_err     = err_q;
    assign lock_bits = lock_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_reglk_arbiter.sv
// Bench for reglk_arbiter: a byte-level reference model and a per-cycle monitor,
// driven by directed transactions with literal expectations on the key results.
module tb_reglk_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  m_req = 2'b00, m_we = 2'b00;
    logic [5:0]  m_width = 6'b0;
    logic [63:0] m_addr = 64'h0, m_wdata = 64'h0;
    logic [1:0]  m_gnt, m_rvalid, m_err;
    logic [31:0] m_rdata;
    logic        mem_we;
    logic [2:0]  mem_width;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [5:0]  lock_bits;
    logic [1:0]  dbg_state;

    reglk_arbiter dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_width(m_width),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata), .m_err(m_err), .mem_we(mem_we), .mem_width(mem_width),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lock_bits(lock_bits), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- shared data memory (the DUT's slave) ----------------
    logic [31:0] mem [0:199];
    initial for (int i = 0; i < 200; i++) mem[i] = 32'h0;

    always_comb begin
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        word = (mem_addr < 32'd800) ? mem[int'(mem_addr >> 2)] : 32'h0;
        b = word[8*mem_addr[1:0] +: 8];
        h = mem_addr[1] ? word[31:16] : word[15:0];
        case (mem_width)
            3'b000:  mem_rdata = {{24{b[7]}}, b};
            3'b001:  mem_rdata = {{16{h[15]}}, h};
            3'b010:  mem_rdata = word;
            3'b100:  mem_rdata = {24'h0, b};
            3'b101:  mem_rdata = {16'h0, h};
            default: mem_rdata = 32'h0;
        endcase
    end

    always @(negedge clk) begin
        if (mem_we && mem_addr < 32'd800) begin
            case (mem_width)
                3'b000, 3'b100: mem[int'(mem_addr >> 2)][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
                3'b001, 3'b101: mem[int'(mem_addr >> 2)][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
                3'b010:         mem[int'(mem_addr >> 2)] <= mem_wdata;
                default: ;
            endcase
        end
    end

    // ---------------- reference model: byte array + lock bits ----------------
    logic [7:0] ref_mem [0:799];
    logic [5:0] ref_lock = 6'b0;
    initial for (int i = 0; i < 800; i++) ref_mem[i] = 8'h0;

    task automatic model_access(input logic we, input logic [2:0] w, input logic [31:0] a,
                                input logic [31:0] d, output logic ewe,
                                output logic [31:0] erd, output logic eerr);
        int size;
        int b;
        logic [31:0] v;
        ewe = 1'b0; erd = 32'h0; eerr = 1'b0;
        size = (w[1:0] == 2'd0) ? 1 : (w[1:0] == 2'd1) ? 2 : 4;
        if (w == 3'b011 || w == 3'b110 || w == 3'b111) eerr = 1'b1;
        else if (a == 32'h60) begin
            if (w != 3'b010) eerr = 1'b1;
            else if (we) ref_lock = ref_lock | d[5:0];
            else erd = {26'h0, ref_lock};
        end else if ((a % size) != 0 || a >= 32'd800) eerr = 1'b1;
        else if (we) begin
            for (int i = 0; i < size; i++) begin
                b = int'(a) + i;
                if (b >= 128 && b < 128 + 6 * 16 && ref_lock[(b - 128) / 16]) eerr = 1'b1;
            end
            if (!eerr) begin
                ewe = 1'b1;
                for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
            end
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
            if (!w[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (!w[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
            erd = v;
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    logic [33:0] exp_q[$];          // {id, err, rdata}
    logic [1:0]  gnt_log[$];
    int          gnt_cyc[$];
    int          ph = 0;            // 0 idle, 1 access, 2 response
    logic        ptr_m = 1'b0;
    logic        c_id, c_we, e_we, e_err;
    logic [2:0]  c_w;
    logic [31:0] c_a, c_d, e_rd;
    logic [31:0] last_rdata;
    logic        last_err;
    int          we_cnt = 0;

    always @(negedge clk) begin
        logic        win;
        logic [33:0] e;
        if (rst) begin
            ph = 0; ptr_m = 1'b0; ref_lock = 6'b0; exp_q.delete();
            check("rst_gnt", m_gnt, 0);
            check("rst_rvalid", m_rvalid, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_lock", lock_bits, 0);
        end else begin
            if (mem_we) we_cnt++;
            check("lock_bits", lock_bits, ref_lock);
            case (ph)
                0: begin
                    win = (m_req == 2'b11) ? ptr_m : m_req[1];
                    check("gnt", m_gnt, (m_req != 0) ? (2'b01 << win) : 2'b00);
                    check("rvalid_idle", m_rvalid, 0);
                    check("mem_we_idle", mem_we, 0);
                    if (m_req != 0) begin
                        c_id = win; c_we = m_we[win]; c_w = m_width[3*win +: 3];
                        c_a = m_addr[32*win +: 32]; c_d = m_wdata[32*win +: 32];
                        ptr_m = ~win; ph = 1;
                        gnt_log.push_back(m_gnt); gnt_cyc.push_back(cyc);
                    end
                end
                1: begin
                    check("gnt_access", m_gnt, 0);
                    check("rvalid_access", m_rvalid, 0);
                    model_access(c_we, c_w, c_a, c_d, e_we, e_rd, e_err);
                    check("mem_we", mem_we, e_we);
                    if (e_we) check("mem_addr", mem_addr, c_a);
                    exp_q.push_back({c_id, e_err, e_rd});
                    ph = 2;
                end
                default: begin
                    check("gnt_resp", m_gnt, 0);
                    check("mem_we_resp", mem_we, 0);
                    if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("rvalid", m_rvalid, 2'b01 << e[33]);
                        check("rdata", m_rdata, e[31:0]);
                        check("err", m_err, e[32] ? (2'b01 << e[33]) : 2'b00);
                    end
                    last_rdata = m_rdata; last_err = |m_err;
                    ph = 0;
                end
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_cmd(input int id, input logic we, input logic [2:0] w,
                             input logic [31:0] a, input logic [31:0] d);
        m_req[id] = 1'b1; m_we[id] = we; m_width[3*id +: 3] = w;
        m_addr[32*id +: 32] = a; m_wdata[32*id +: 32] = d;
    endtask

    task automatic do_txn(input int id, input logic we, input logic [2:0] w,
                          input logic [31:0] a, input logic [31:0] d, output int waits);
        @(posedge clk); #1;
        drive_cmd(id, we, w, a, d);
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (m_gnt[id]) break;
            waits++;
            if (waits > 20) begin check("gnt_timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
        m_req[id] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2; rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #2; rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int we0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        check("reset_state", dbg_state, 2'd0);
        check("reset_lock", lock_bits, 0);
        check("reset_rdata", m_rdata, 0);

        // R0 word write then readback
        we0 = we_cnt;
        do_txn(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, w);
        check("t1_gnt_same_cycle", w, 0);
        check("t1_mem_we_once", we_cnt - we0, 1);
        check("t1_err", last_err, 0);
        do_txn(0, 1'b0, 3'b010, 32'h10, 32'h0, w);
        check("t1_readback", last_rdata, 32'hDEAD_BEEF);

        // Both requesting continuously right after reset
        pulse_reset();
        gnt_log.delete(); gnt_cyc.delete();
        @(posedge clk); #1;
        drive_cmd(0, 1'b0, 3'b010, 32'h0, 32'h0);
        drive_cmd(1, 1'b0, 3'b010, 32'h4, 32'h0);
        for (int i = 0; i < 40 && gnt_log.size() < 4; i++) @(posedge clk);
        #1 m_req = 2'b00;
        check("t2_grant_count", gnt_log.size() >= 4, 1);
        if (gnt_log.size() >= 4) begin
            check("t2_g0", gnt_log[0], 2'b01);
            check("t2_g1", gnt_log[1], 2'b10);
            check("t2_g2", gnt_log[2], 2'b01);
            check("t2_g3", gnt_log[3], 2'b10);
            for (int i = 1; i < 4; i++) check("t2_spacing", gnt_cyc[i] - gnt_cyc[i-1], 3);
        end
        repeat (3) @(posedge clk); #1;

        // Lock region 0, then R1 write into it must be dropped
        do_txn(0, 1'b1, 3'b010, 32'h84, 32'hCAFE_F00D, w);
        do_txn(0, 1'b1, 3'b010, 32'h60, 32'h1, w);
        check("t3_lock_set", lock_bits, 6'b000001);
        we0 = we_cnt;
        do_txn(1, 1'b1, 3'b010, 32'h84, 32'h1111_2222, w);
        check("t3_locked_err", last_err, 1);
        check("t3_no_mem_we", we_cnt - we0, 0);
        do_txn(1, 1'b0, 3'b010, 32'h84, 32'h0, w);
        check("t3_unchanged", last_rdata, 32'hCAFE_F00D);

        // Writing zero cannot clear a lock
        do_txn(1, 1'b1, 3'b010, 32'h60, 32'h0, w);
        check("t4_err", last_err, 0);
        check("t4_sticky", lock_bits, 6'b000001);
        do_txn(1, 1'b0, 3'b010, 32'h60, 32'h0, w);
        check("t4_lock_read", last_rdata, 32'h0000_0001);

        // Width / alignment errors and byte sign extension
        we0 = we_cnt;
        do_txn(0, 1'b1, 3'b001, 32'h21, 32'hFFFF, w);
        check("t5_sh_mis_err", last_err, 1);
        check("t5_sh_mis_rdata", last_rdata, 0);
        do_txn(0, 1'b1, 3'b011, 32'h20, 32'hFFFF, w);
        check("t5_illegal_err", last_err, 1);
        check("t5_no_write", we_cnt - we0, 0);
        do_txn(1, 1'b0, 3'b111, 32'h20, 32'h0, w);
        check("t5_illegal_rd_rdata", last_rdata, 0);
        do_txn(0, 1'b1, 3'b000, 32'h23, 32'h80, w);
        do_txn(0, 1'b0, 3'b000, 32'h23, 32'h0, w);
        check("t5_sb_read", last_rdata, 32'hFFFF_FF80);
        do_txn(1, 1'b0, 3'b100, 32'h23, 32'h0, w);
        check("t5_ub_read", last_rdata, 32'h0000_0080);
        do_txn(1, 1'b0, 3'b010, 32'h320, 32'h0, w);
        check("t5_out_of_range", last_err, 1);

        // Reset in the middle of a write's ACCESS cycle
        do_txn(0, 1'b1, 3'b010, 32'h30, 32'h1234_5678, w);
        @(posedge clk); #1;
        drive_cmd(0, 1'b1, 3'b010, 32'h30, 32'hFFFF_FFFF);
        @(negedge clk);
        check("t6_gnt", m_gnt, 2'b01);
        @(posedge clk); #1;
        check("t6_pre_mem_we", mem_we, 1);
        check("t6_pre_lock", lock_bits, 6'b000001);
        #1 rst = 1'b1;
        #1;
        check("t6_mem_we_drop", mem_we, 0);
        check("t6_state_idle", dbg_state, 2'd0);
        check("t6_lock_cleared", lock_bits, 0);
        check("t6_no_rvalid", m_rvalid, 0);
        m_req = 2'b00;
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        do_txn(1, 1'b0, 3'b010, 32'h30, 32'h0, w);
        check("t6_word_unchanged", last_rdata, 32'h1234_5678);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reglk_arbiter.md
Name: reglk_arbiter

Overview:
- Two-requester arbiter and lock enforcer in front of the shared byte-addressable data memory (200 x 32-bit words, mem_width-encoded accesses, negedge write).
- Requester 0 is the core and requester 1 is the debug/JTAG port.
- Holds a sticky lock register that only the global reset clears. Neither requester can clear it or bypass it.
- Any write that targets a locked region is dropped and flagged as an error.

Parameters:
NUM_LOCKS, 6, number of lock bits / protected regions
LOCK_ADDR, 32'h0000_0060, byte address of the lock register (internal; never forwarded to memory)
LOCK_BASE, 32'h0000_0080, byte address of protected region 0
REGION_WORDS, 4, words per protected region; region k = LOCK_BASE + k*REGION_WORDS*4 ... +REGION_WORDS*4-1

Ports:
clk  in  1  system clock; all state on posedge
rst  in  1  asynchronous active-high reset
m_req  in  2  per-requester request; bit i = requester i
m_we  in  2  per-requester write enable
m_width  in  6  per-requester mem_width, [3i+2:3i]
m_addr  in  64  per-requester byte address, [32i+31:32i]
m_wdata  in  64  per-requester write data, [32i+31:32i]
m_gnt  out  2  one-hot grant pulse
m_rvalid  out  2  one-hot response-valid pulse
m_rdata  out  32  response data, shared, qualified by m_rvalid
m_err  out  2  error flag, qualified by m_rvalid
mem_we  out  1  memory write enable
mem_width  out  3  memory access width
mem_addr  out  32  memory byte address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory combinational read data (already width-formatted)
lock_bits  out  NUM_LOCKS  current lock register

Behaviour:
- Reset (async, immediate): FSM=IDLE; RR pointer favours requester 0; lock_bits=0; all m_* outputs 0; mem_we=0; mem_width/mem_addr/mem_wdata=0.
- Width codes: 000 SB, 001 SH, 010 W, 100 UB, 101 UH. Codes 011/110/111 are illegal.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any m_req bit is set, pick a winner: the only requester, or on a tie the pointer's requester.
  - Assert m_gnt[winner] combinationally in this cycle.
  - On the posedge, latch winner id, we, width, addr and wdata; move the pointer to the other requester; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS (exactly one cycle):
  - Drive mem_addr/mem_width/mem_wdata from the latched command.
  - Assert mem_we only if the access is a permitted write.
  - On the posedge, capture the response and go to RESP.
- RESP (one cycle):
  - m_rvalid[id]=1, m_rdata and m_err valid; go to IDLE.
  - Throughput is one access per 3 cycles. Grant-to-rvalid latency is 2 cycles.
- Error conditions (err=1, no memory write, rdata=0):
  - illegal width code;
  - misaligned access: SH/UH with addr[0]=1, or W with addr[1:0]!=0;
  - write to any byte inside region k while lock_bits[k]=1;
  - any address >= 200*4 other than LOCK_ADDR.
- Lock register access (addr==LOCK_ADDR, must be W width, else err):
  - Write: lock_bits <= lock_bits | wdata[NUM_LOCKS-1:0] at the end of ACCESS. mem_we stays 0. err=0.
  - Read: rdata = zero-extended lock_bits. Memory is not accessed, mem_we=0.
  - Bits are sticky. Writing 0 never clears a bit; only rst clears them.
  - No soft, debug or partial reset path exists.
- Permitted write: rdata=0, err=0.
- Permitted read: rdata = mem_rdata sampled at the posedge ending ACCESS.
- Lock check uses lock_bits as they stand during ACCESS. A lock set by the immediately preceding transaction is already effective.
- Requester rule: hold req and command stable until m_gnt. A request still high in the cycle after RESP is a new request.
- Requests arriving during ACCESS/RESP are ignored until IDLE.
- mem_we is decoded from the state register. Reset during ACCESS deasserts it before the next negedge memory write.

Test Plan:
- Reset then R0 writes W 32'hDEAD_BEEF to 0x10 -> m_gnt=01 in the request cycle; mem_we=1 for one cycle; m_rvalid=01 2 cycles after grant, err=0. R0 read of 0x10 returns 32'hDEAD_BEEF.
- Both requesters request continuously -> grants alternate 01,10,01,10, each 3 cycles apart. The first grant after reset goes to R0.
- R0 writes 32'h1 to 0x60, then R1 writes W to 0x84 -> lock_bits=000001; R1 gets err=1; mem_we never asserts; readback of 0x84 is unchanged.
- R1 writes 32'h0 to 0x60 after lock set -> lock_bits stays 000001, err=0. Read of 0x60 returns 32'h0000_0001.
- SH at 0x21 and width 3'b011 at 0x20 -> err=1, rdata=0, no write. SB 8'h80 at 0x23 followed by SB read -> 32'hFFFF_FF80; UB read -> 32'h0000_0080.
- Assert rst mid-ACCESS of a write to 0x30 -> mem_we drops immediately, word 0x30 is unchanged, FSM=IDLE, lock_bits=0, no m_rvalid.
